// File: rtl/title_loader_pkg.sv
// Shared constants, FSM encoding and code-to-font-address helper for the title loader.
package title_loader_pkg;

  localparam int NUM_CHARS      = 12;
  localparam int CODE_W         = 6;
  localparam int ROM_BASE_W     = 9;
  localparam int FONT_ROWS_LOG2 = 3;
  localparam int IDX_W          = 4;

  localparam logic [CODE_W-1:0] DEF_BLANK_CODE = 6'd0;
  localparam logic [CODE_W-1:0] DEF_END_CODE   = 6'h3F;
  localparam logic [IDX_W-1:0]  LAST_IDX       = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

  // Each glyph occupies 2**FONT_ROWS_LOG2 rows in the font ROM.
  function automatic logic [ROM_BASE_W-1:0] font_base(input logic [CODE_W-1:0] code);
    return {code, {FONT_ROWS_LOG2{1'b0}}};
  endfunction

endpackage

// File: rtl/title_shadow_buffer.sv
// 12-entry shadow of char codes, written one slot at a time, committed in parallel
// into the visible font-base-address registers.
module title_shadow_buffer
  import title_loader_pkg::*;
#(
  parameter logic [CODE_W-1:0] BLANK_CODE = DEF_BLANK_CODE
) (
  input  logic                                clk_i,
  input  logic                                reset_ni,
  input  logic                                wr_en_i,
  input  logic [IDX_W-1:0]                    wr_idx_i,
  input  logic [CODE_W-1:0]                   wr_code_i,
  input  logic                                commit_i,
  output logic [NUM_CHARS*ROM_BASE_W-1:0]     chars_o
);

  logic [CODE_W-1:0]     shadow_q [NUM_CHARS];
  logic [ROM_BASE_W-1:0] char_q   [NUM_CHARS];

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < NUM_CHARS; i++) begin
        shadow_q[i] <= BLANK_CODE;
        char_q[i]   <= font_base(BLANK_CODE);
      end
    end else begin
      if (wr_en_i && (wr_idx_i <= LAST_IDX)) begin
        shadow_q[wr_idx_i] <= wr_code_i;
      end
      if (commit_i) begin
        for (int i = 0; i < NUM_CHARS; i++) begin
          char_q[i] <= font_base(shadow_q[i]);
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CHARS; g++) begin : g_out
    assign chars_o[g*ROM_BASE_W +: ROM_BASE_W] = char_q[g];
  end

endmodule

// File: rtl/title_loader.sv
// Fetches a 12-char title from the title-text ROM into a shadow buffer and commits it
// to the char1..char12 font base outputs in one edge, optionally aligned to frame_start.
module title_loader
  import title_loader_pkg::*;
#(
  parameter int                TITLE_ID_W    = 3,
  parameter logic [CODE_W-1:0] BLANK_CODE    = DEF_BLANK_CODE,
  parameter logic [CODE_W-1:0] END_CODE      = DEF_END_CODE,
  parameter bit                SYNC_TO_FRAME = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        load_req,
  input  logic [TITLE_ID_W-1:0]       title_id,
  input  logic                        frame_start,
  output logic [TITLE_ID_W+IDX_W-1:0] rom_addr,
  input  logic [CODE_W-1:0]           rom_data,
  output logic [ROM_BASE_W-1:0]       char1,
  output logic [ROM_BASE_W-1:0]       char2,
  output logic [ROM_BASE_W-1:0]       char3,
  output logic [ROM_BASE_W-1:0]       char4,
  output logic [ROM_BASE_W-1:0]       char5,
  output logic [ROM_BASE_W-1:0]       char6,
  output logic [ROM_BASE_W-1:0]       char7,
  output logic [ROM_BASE_W-1:0]       char8,
  output logic [ROM_BASE_W-1:0]       char9,
  output logic [ROM_BASE_W-1:0]       char10,
  output logic [ROM_BASE_W-1:0]       char11,
  output logic [ROM_BASE_W-1:0]       char12,
  output logic                        busy,
  output logic                        done,
  output logic [1:0]                  dbg_state
);

  // Request protocol: load_req is a fire-and-forget pulse; it is always accepted.
  // While busy it is parked in a single pending slot (latest id wins).
  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [TITLE_ID_W-1:0]   id_q, id_d;
  logic [TITLE_ID_W-1:0]   pend_id_q, pend_id_d;
  logic                    pend_q, pend_d;
  logic                    end_seen_q, end_seen_d;
  logic                    done_q, done_d;

  logic                    wr_en;
  logic [IDX_W-1:0]        wr_idx;
  logic [CODE_W-1:0]       cap_code;
  logic                    commit;
  logic [NUM_CHARS*ROM_BASE_W-1:0] chars;

  // Once the terminator has been seen, every later slot is padded with blanks.
  assign cap_code = (end_seen_q || (rom_data == END_CODE)) ? BLANK_CODE : rom_data;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    id_d       = id_q;
    pend_d     = pend_q;
    pend_id_d  = pend_id_q;
    end_seen_d = end_seen_q;
    done_d     = 1'b0;
    wr_en      = 1'b0;
    wr_idx     = idx_q - 4'd1;
    commit     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_req || pend_q) begin
          state_d    = ST_FETCH;
          idx_d      = '0;
          end_seen_d = 1'b0;
          if (pend_q) begin
            id_d      = pend_id_q;
            pend_d    = load_req;
            pend_id_d = load_req ? title_id : pend_id_q;
          end else begin
            id_d = title_id;
          end
        end
      end
      ST_FETCH: begin
        idx_d = idx_q + 4'd1;
        if (idx_q != '0) begin
          wr_en      = 1'b1;
          end_seen_d = end_seen_q | (rom_data == END_CODE);
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        wr_en      = 1'b1;
        wr_idx     = LAST_IDX;
        end_seen_d = end_seen_q | (rom_data == END_CODE);
        state_d    = ST_COMMIT;
      end
      ST_COMMIT: begin
        if (!SYNC_TO_FRAME || frame_start) begin
          commit  = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if ((state_q != ST_IDLE) && load_req) begin
      pend_d    = 1'b1;
      pend_id_d = title_id;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      id_q       <= '0;
      pend_q     <= 1'b0;
      pend_id_q  <= '0;
      end_seen_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      id_q       <= id_d;
      pend_q     <= pend_d;
      pend_id_q  <= pend_id_d;
      end_seen_q <= end_seen_d;
      done_q     <= done_d;
    end
  end

  title_shadow_buffer #(
    .BLANK_CODE (BLANK_CODE)
  ) u_shadow (
    .clk_i     (clk),
    .reset_ni  (reset_n),
    .wr_en_i   (wr_en),
    .wr_idx_i  (wr_idx),
    .wr_code_i (cap_code),
    .commit_i  (commit),
    .chars_o   (chars)
  );

  assign rom_addr  = (state_q == ST_FETCH) ? {id_q, idx_q} : '0;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign dbg_state = state_q;

  assign char1  = chars[0*ROM_BASE_W  +: ROM_BASE_W];
  assign char2  = chars[1*ROM_BASE_W  +: ROM_BASE_W];
  assign char3  = chars[2*ROM_BASE_W  +: ROM_BASE_W];
  assign char4  = chars[3*ROM_BASE_W  +: ROM_BASE_W];
  assign char5  = chars[4*ROM_BASE_W  +: ROM_BASE_W];
  assign char6  = chars[5*ROM_BASE_W  +: ROM_BASE_W];
  assign char7  = chars[6*ROM_BASE_W  +: ROM_BASE_W];
  assign char8  = chars[7*ROM_BASE_W  +: ROM_BASE_W];
  assign char9  = chars[8*ROM_BASE_W  +: ROM_BASE_W];
  assign char10 = chars[9*ROM_BASE_W  +: ROM_BASE_W];
  assign char11 = chars[10*ROM_BASE_W +: ROM_BASE_W];
  assign char12 = chars[11*ROM_BASE_W +: ROM_BASE_W];

endmodule

// File: tb/tb_title_loader.sv
// Bench for title_loader: one immediate-commit instance and one frame-synchronised instance
// sharing a title-text ROM model; committed titles are checked against an expected queue.
module tb_title_loader;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         lr0 = 1'b0, lr1 = 1'b0;
  logic [2:0]   tid0 = '0, tid1 = '0;
  logic         frame_start = 1'b0;
  logic [6:0]   rom_addr0, rom_addr1;
  logic [5:0]   rom_data0, rom_data1;
  wire  [107:0] chars0_v, chars1_v;
  logic         busy0, busy1, done0, done1;
  logic [1:0]   dbg0, dbg1;

  logic [5:0]   rom_mem [0:127];
  logic [107:0] exp_q0 [$];
  logic [107:0] exp_q1 [$];
  int total = 0;
  int bad = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- ROM models ----------------
  always @(posedge clk) begin
    rom_data0 <= rom_mem[rom_addr0];
    rom_data1 <= rom_mem[rom_addr1];
  end

  title_loader #(.TITLE_ID_W(3), .SYNC_TO_FRAME(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .load_req(lr0), .title_id(tid0),
    .frame_start(frame_start), .rom_addr(rom_addr0), .rom_data(rom_data0),
    .char1(chars0_v[8:0]),     .char2(chars0_v[17:9]),   .char3(chars0_v[26:18]),
    .char4(chars0_v[35:27]),   .char5(chars0_v[44:36]),  .char6(chars0_v[53:45]),
    .char7(chars0_v[62:54]),   .char8(chars0_v[71:63]),  .char9(chars0_v[80:72]),
    .char10(chars0_v[89:81]),  .char11(chars0_v[98:90]), .char12(chars0_v[107:99]),
    .busy(busy0), .done(done0), .dbg_state(dbg0)
  );

  title_loader #(.TITLE_ID_W(3), .SYNC_TO_FRAME(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .load_req(lr1), .title_id(tid1),
    .frame_start(frame_start), .rom_addr(rom_addr1), .rom_data(rom_data1),
    .char1(chars1_v[8:0]),     .char2(chars1_v[17:9]),   .char3(chars1_v[26:18]),
    .char4(chars1_v[35:27]),   .char5(chars1_v[44:36]),  .char6(chars1_v[53:45]),
    .char7(chars1_v[62:54]),   .char8(chars1_v[71:63]),  .char9(chars1_v[80:72]),
    .char10(chars1_v[89:81]),  .char11(chars1_v[98:90]), .char12(chars1_v[107:99]),
    .busy(busy1), .done(done1), .dbg_state(dbg1)
  );

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference title: codes padded with blanks from the first terminator onwards.
  function automatic logic [107:0] model_chars(input int id);
    logic [107:0] v;
    logic [5:0]   c;
    bit           ended;
    v = '0;
    ended = 1'b0;
    for (int k = 0; k < 12; k++) begin
      c = rom_mem[id*16 + k];
      if (c == 6'h3F) ended = 1'b1;
      if (ended) c = 6'd0;
      v[k*9 +: 9] = {c, 3'b000};
    end
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (done0) begin
      if (exp_q0.size() == 0) check_eq("sb0_extra_done", done0, 1'b0);
      else check_eq("sb0_chars", chars0_v, exp_q0.pop_front());
    end
    if (done1) begin
      if (exp_q1.size() == 0) check_eq("sb1_extra_done", done1, 1'b0);
      else check_eq("sb1_chars", chars1_v, exp_q1.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic drive_req0(input int id);
    lr0  = 1'b1;
    tid0 = 3'(id);
    exp_q0.push_back(model_chars(id));
    @(negedge clk);
    lr0 = 1'b0;
  endtask

  task automatic run_load0(input int id, input string tag);
    int n;
    drive_req0(id);
    check_eq({tag, "_busy"}, busy0, 1'b1);
    for (int k = 0; k < 12; k++) begin
      check_eq({tag, "_addr"}, rom_addr0, {3'(id), 4'(k)});
      @(negedge clk);
    end
    n = 13;
    while (!done0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_latency"}, n - 1, 14);
    check_eq({tag, "_busy_off"}, busy0, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int a = 0; a < 128; a++) rom_mem[a] = 6'($urandom_range(0, 63));
    for (int k = 0; k < 12; k++) rom_mem[32 + k] = 6'(k + 1);
    rom_mem[64] = 6'd5; rom_mem[65] = 6'd7; rom_mem[66] = 6'h3F;
    for (int k = 3; k < 12; k++) rom_mem[64 + k] = 6'(k + 6);

    repeat (3) @(negedge clk);
    check_eq("rst_chars0", chars0_v, 108'd0);
    check_eq("rst_chars1", chars1_v, 108'd0);
    check_eq("rst_busy", {busy0, busy1}, 2'b00);
    check_eq("rst_done", {done0, done1}, 2'b00);
    check_eq("rst_addr", rom_addr0, 7'h00);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // codes 1..12 from title 2
    run_load0(2, "seq");
    check_eq("seq_c1", chars0_v[8:0], 9'h008);
    check_eq("seq_c12", chars0_v[107:99], 9'h060);
    @(negedge clk);

    // terminator in slot 3 of title 4
    run_load0(4, "term");
    check_eq("term_c1", chars0_v[8:0], 9'h028);
    check_eq("term_c2", chars0_v[17:9], 9'h038);
    check_eq("term_rest", chars0_v[107:18], 90'd0);
    @(negedge clk);

    // random titles from the randomly filled ROM
    for (int r = 0; r < 3; r++) begin
      int id;
      id = $urandom_range(0, 7);
      if (id == 2 || id == 4) id = 7;
      run_load0(id, "rand");
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // frame-synchronised commit; an early frame_start during fetch must be ignored
    lr1 = 1'b1; tid1 = 3'd2;
    exp_q1.push_back(model_chars(2));
    @(negedge clk);
    lr1 = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      check_eq("sync_busy", busy1, 1'b1);
      check_eq("sync_done_early", done1, 1'b0);
      check_eq("sync_hold", chars1_v, 108'd0);
      frame_start = (n == 5) || (n == 40);
      @(negedge clk);
    end
    frame_start = 1'b0;
    check_eq("sync_done", done1, 1'b1);
    check_eq("sync_busy_off", busy1, 1'b0);
    check_eq("sync_c12", chars1_v[107:99], 9'h060);
    repeat (2) @(negedge clk);

    // requests during fetch: id 1 then id 3, only id 3 is loaded after id 0
    drive_req0(0);
    for (int n = 1; n <= 15; n++) begin
      if (n <= 12) check_eq("pend_addr_a", rom_addr0, {3'd0, 4'(n - 1)});
      if (n == 14) check_eq("pend_done_early", done0, 1'b0);
      if (n == 15) check_eq("pend_done_a", done0, 1'b1);
      lr0  = (n == 3) || (n == 6);
      tid0 = (n == 3) ? 3'd1 : 3'd3;
      if (n == 3) exp_q0.push_back(model_chars(1));
      if (n == 6) exp_q0[exp_q0.size() - 1] = model_chars(3);
      @(negedge clk);
    end
    for (int n = 16; n <= 30; n++) begin
      if (n <= 27) check_eq("pend_addr_b", rom_addr0, {3'd3, 4'(n - 16)});
      if (n == 30) check_eq("pend_done_b", done0, 1'b1);
      @(negedge clk);
    end
    check_eq("pend_idle", {busy0, rom_addr0}, 8'h00);
    repeat (3) @(negedge clk);

    // reset during fetch at idx 6
    drive_req0(5);
    for (int n = 1; n < 7; n++) @(negedge clk);
    check_eq("rst_mid_addr6", rom_addr0, {3'd5, 4'd6});
    reset_n = 1'b0;
    #1;
    check_eq("rst_mid_chars", chars0_v, 108'd0);
    check_eq("rst_mid_busy", busy0, 1'b0);
    check_eq("rst_mid_addr", rom_addr0, 7'h00);
    exp_q0.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_load0(6, "post_rst");

    repeat (5) @(negedge clk);
    check_eq("sb0_empty", exp_q0.size(), 0);
    check_eq("sb1_empty", exp_q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
